vga_sync_decoder: RTL
=====================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA sync/colour generator. Takes the pixel-clock-synchronous
//  HSync/VSync/RGB stream, rebuilds pixel X/Y, checks 640x480 timing, declares lock, and
//  forwards visible pixels with their coordinates. Used as an on-chip loopback monitor and
//  frame-capture front end (collision/readback logic).
// PARAMETERS
//  H_VISIBLE_AREA  640  visible pixels per line
//  H_FRONT_PORCH   16   pixels between visible end and HSync fall
//  H_SYNC_PULSE    96   HSync low width, pixels
//  H_TOTAL         800  pixels per line
//  V_VISIBLE_AREA  480  visible lines per frame
//  V_FRONT_PORCH   10   lines between visible end and VSync fall
//  V_SYNC_PULSE    2    VSync low width, lines
//  V_TOTAL         525  lines per frame
//  LOCK_FRAMES     2    consecutive error-free frames required for lock (1..7)
// PORTS
//  i_Clk         in   1   pixel clock (same clock that drives the source stream)
//  i_Rst_L       in   1   asynchronous reset, active low
//  i_HSync       in   1   horizontal sync, active low
//  i_VSync       in   1   vertical sync, active low
//  i_Red         in   3   red, aligned with syncs
//  i_Grn         in   3   green
//  i_Blu         in   3   blue
//  o_X           out  10  reconstructed column of o_Red/o_Grn/o_Blu
//  o_Y           out  10  reconstructed line
//  o_Active      out  1   1 = locked and (o_X,o_Y) inside visible area
//  o_Red         out  3   i_Red delayed, forced 0 when o_Active=0
//  o_Grn         out  3   as o_Red
//  o_Blu         out  3   as o_Red
//  o_Frame_Start out  1   1-cycle pulse: o_X=0,o_Y=0 while locked
//  o_Locked      out  1   lock state
//  o_Timing_Err  out  1   1-cycle pulse on any timing violation in TRACK/LOCKED
// BEHAVIOUR
//  - Reset (async, i_Rst_L=0): all outputs 0, counters 0, state SEARCH, good-frame count 0.
//  - Inputs registered once; edges detected from registered vs previous registered value.
//    Outputs registered; total latency input->output = 2 cycles. Syncs and RGB share alignment.
//  - H_SYNC_START = H_VISIBLE_AREA+H_FRONT_PORCH (656); V_SYNC_START = V_VISIBLE_AREA+V_FRONT_PORCH (490).
//  - h_cnt: on HSync fall loads H_SYNC_START (any state); else increments, H_TOTAL-1 wraps to 0.
//  - v_cnt: on VSync fall loads V_SYNC_START; else increments when h_cnt wraps, V_TOTAL-1 -> 0.
//    Load has priority over increment when both occur in the same cycle.
//  - Predicted value = free-running next count (what counter would hold without load).
//  - Errors (checked only in TRACK/LOCKED):
//    HSync fall with predicted h != H_SYNC_START; HSync rise with h != H_SYNC_START+H_SYNC_PULSE;
//    predicted h == H_SYNC_START while HSync still high (missing pulse);
//    VSync fall with predicted v != V_SYNC_START or while h != H_SYNC_START-? not checked;
//    VSync rise with v != V_SYNC_START+V_SYNC_PULSE; v reaches V_SYNC_START at h wrap with VSync high.
//  - FSM: SEARCH -(VSync fall)-> TRACK, good=0.
//    TRACK: VSync fall with no error since previous fall -> good+1; good==LOCK_FRAMES -> LOCKED.
//    TRACK/LOCKED: any error -> SEARCH next cycle, o_Timing_Err=1 one cycle, o_Locked=0 next cycle.
//  - o_Locked=1 iff state LOCKED. o_Active = LOCKED && h<H_VISIBLE_AREA && v<V_VISIBLE_AREA.
//  - o_Frame_Start asserts with the output cycle carrying X=0,Y=0 only while LOCKED.
//  - Counter realignment on an error edge still happens (counters follow stream); relock needs
//    full LOCK_FRAMES again. Reset mid-frame: restart in SEARCH, no error pulse.
// TESTING
//  1 Reset, then clean 640x480 stream from generator -> o_Locked rises 2 cycles after 3rd VSync fall; no o_Timing_Err.
//  2 Locked, source pixel (100,50) = R7 G0 B7 -> two cycles later o_X=100,o_Y=50,o_Active=1,RGB=7/0/7.
//  3 Locked, blanking pixel (700,10) with nonzero RGB -> o_Active=0, o_Red/Grn/Blu=0.
//  4 Locked, HSync fall shifted 3 pixels early on one line -> one o_Timing_Err pulse, o_Locked=0,
//    relock after 3 further VSync falls.
//  5 Locked, one HSync pulse omitted -> error when h reaches 656 with HSync high; state SEARCH.
//  6 i_Rst_L low mid-line for 1 cycle -> all outputs 0 immediately, o_Timing_Err stays 0, relock as in 1.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// Stream interface between a VGA sync/colour source and the receive-side decoder.
interface vga_sync_decoder_if;
    logic       i_HSync;
    logic       i_VSync;
    logic [2:0] i_Red;
    logic [2:0] i_Grn;
    logic [2:0] i_Blu;
    logic [9:0] o_X;
    logic [9:0] o_Y;
    logic       o_Active;
    logic [2:0] o_Red;
    logic [2:0] o_Grn;
    logic [2:0] o_Blu;
    logic       o_Frame_Start;
    logic       o_Locked;
    logic       o_Timing_Err;

    // Stream source / observer side.
    modport master (
        output i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
        input  o_X, o_Y, o_Active, o_Red, o_Grn, o_Blu,
        input  o_Frame_Start, o_Locked, o_Timing_Err
    );

    // Decoder side.
    modport slave (
        input  i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
        output o_X, o_Y, o_Active, o_Red, o_Grn, o_Blu,
        output o_Frame_Start, o_Locked, o_Timing_Err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: rebuilds X/Y from HSync/VSync, checks timing,
// declares lock after clean frames and forwards visible pixels with coordinates.
module vga_sync_decoder #(
    parameter int unsigned H_VISIBLE_AREA = 640,
    parameter int unsigned H_FRONT_PORCH  = 16,
    parameter int unsigned H_SYNC_PULSE   = 96,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_VISIBLE_AREA = 480,
    parameter int unsigned V_FRONT_PORCH  = 10,
    parameter int unsigned V_SYNC_PULSE   = 2,
    parameter int unsigned V_TOTAL        = 525,
    parameter int unsigned LOCK_FRAMES    = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    vga_sync_decoder_if.slave vga
);
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned GOOD_W = 3;

    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_VISIBLE_AREA);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_VISIBLE_AREA);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_e;

    logic             hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [COL_W-1:0] red_q, grn_q, blu_q;
    logic             hs_fall_c, hs_rise_c, vs_fall_c, vs_rise_c;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, h_pred_c, v_pred_c;
    logic             h_wrap_c, err_c, timing_err_c;
    state_e           state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic             active_q, active_d, frame_start_q, frame_start_d;
    logic             locked_q, locked_d, timing_err_q;
    logic [COL_W-1:0] red_o_q, red_o_d, grn_o_q, grn_o_d, blu_o_q, blu_o_d;

    // Input capture stage plus one-deep history for edge detection.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            red_q     <= '0;
            grn_q     <= '0;
            blu_q     <= '0;
        end else begin
            hs_q      <= vga.i_HSync;
            vs_q      <= vga.i_VSync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            red_q     <= vga.i_Red;
            grn_q     <= vga.i_Grn;
            blu_q     <= vga.i_Blu;
        end
    end

    assign hs_fall_c = hs_prev_q & ~hs_q;
    assign hs_rise_c = ~hs_prev_q & hs_q;
    assign vs_fall_c = vs_prev_q & ~vs_q;
    assign vs_rise_c = ~vs_prev_q & vs_q;

    // Free-running prediction, sync-fall realignment, and timing violation detection.
    always_comb begin
        h_wrap_c = (h_cnt_q == H_LAST);
        h_pred_c = h_wrap_c ? '0 : h_cnt_q + CNT_W'(1);
        v_pred_c = v_cnt_q;
        if (h_wrap_c) begin
            v_pred_c = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
        h_cnt_d = hs_fall_c ? H_SYNC_START : h_pred_c;
        v_cnt_d = vs_fall_c ? V_SYNC_START : v_pred_c;
        err_c   = (hs_fall_c && (h_pred_c != H_SYNC_START))
               || (hs_rise_c && (h_pred_c != H_SYNC_END))
               || (hs_q && (h_pred_c == H_SYNC_START))
               || (vs_fall_c && (v_pred_c != V_SYNC_START))
               || (vs_rise_c && (v_pred_c != V_SYNC_END))
               || (h_wrap_c && vs_q && (v_pred_c == V_SYNC_START));
        timing_err_c = err_c && (state_q != ST_SEARCH);
    end

    // Pixel counters; h_cnt_q/v_cnt_q are the coordinates of the pixel on the outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Lock FSM next state: count clean frames between VSync falls, drop on any violation.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall_c) begin
                    state_d = ST_TRACK;
                    good_d  = '0;
                end
            end
            ST_TRACK: begin
                if (timing_err_c) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (vs_fall_c) begin
                    good_d = good_q + GOOD_W'(1);
                    if (good_q + GOOD_W'(1) == LOCK_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (timing_err_c) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // Output decode for the pixel currently in the capture stage.
    always_comb begin
        locked_d      = (state_d == ST_LOCKED);
        active_d      = locked_d && (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        frame_start_d = locked_d && (h_cnt_d == '0) && (v_cnt_d == '0);
        red_o_d       = active_d ? red_q : '0;
        grn_o_d       = active_d ? grn_q : '0;
        blu_o_d       = active_d ? blu_q : '0;
    end

    // Output register stage.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            red_o_q       <= '0;
            grn_o_q       <= '0;
            blu_o_q       <= '0;
        end else begin
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_c;
            red_o_q       <= red_o_d;
            grn_o_q       <= grn_o_d;
            blu_o_q       <= blu_o_d;
        end
    end

    assign vga.o_X           = h_cnt_q;
    assign vga.o_Y           = v_cnt_q;
    assign vga.o_Active      = active_q;
    assign vga.o_Red         = red_o_q;
    assign vga.o_Grn         = grn_o_q;
    assign vga.o_Blu         = blu_o_q;
    assign vga.o_Frame_Start = frame_start_q;
    assign vga.o_Locked      = locked_q;
    assign vga.o_Timing_Err  = timing_err_q;
endmodule
